lb_tile_ctrl: RTL and testbench

LB_TILE_CTRL -- requirements
Module: lb_tile_ctrl

---
 rtl/lb_tile_ctrl_pkg.sv | 26 ++
 rtl/lb_tile_pos_cnt.sv | 51 +++++
 rtl/lb_tile_ctrl.sv | 125 ++++++++++++
 tb/tb_lb_tile_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lb_tile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lb_tile_ctrl_pkg
// Brief    : Shared constants and state encoding for the tile line-buffer controller
// Revision : 1.0 - initial release
// ============================================================================
package lb_tile_ctrl_pkg;

  localparam int c_tile_n  = 8;
  localparam int c_tiles_x = 240;
  localparam int c_tiles_y = 135;
  localparam int c_idx_w   = 8;

  localparam int c_st_w = 2;
  typedef logic [c_st_w-1:0] state_t;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_fill  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lb_tile_pos_cnt.sv
`default_nettype none
// ============================================================================
// Module   : lb_tile_pos_cnt
// Brief    : Raster-order x/y tile position counter with first/last tile flags
// Revision : 1.0 - initial release
// ============================================================================
module lb_tile_pos_cnt
  import lb_tile_ctrl_pkg::*;
#(
  parameter int TILES_X = c_tiles_x,
  parameter int TILES_Y = c_tiles_y,
  parameter int IDX_W   = c_idx_w
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [IDX_W-1:0] o_x,
  output logic [IDX_W-1:0] o_y,
  output logic             o_first,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] c_x_max = IDX_W'(TILES_X - 1);
  localparam logic [IDX_W-1:0] c_y_max = IDX_W'(TILES_Y - 1);
  localparam logic [IDX_W-1:0] c_one   = IDX_W'(1);

  logic [IDX_W-1:0] r_x;
  logic [IDX_W-1:0] r_y;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (r_x == c_x_max) begin
        r_x <= '0;
        r_y <= (r_y == c_y_max) ? '0 : r_y + c_one;
      end else begin
        r_x <= r_x + c_one;
      end
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_first = (r_x == '0) && (r_y == '0);
  assign o_last  = (r_x == c_x_max) && (r_y == c_y_max);

endmodule
`default_nettype wire

// File: rtl/lb_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lb_tile_ctrl
// Brief    : Fill/drain sequencer for an 8x8 transposing line buffer over a frame
// Revision : 1.0 - initial release
// ============================================================================
module lb_tile_ctrl
  import lb_tile_ctrl_pkg::*;
#(
  parameter int TILE_N  = c_tile_n,
  parameter int TILES_X = c_tiles_x,
  parameter int TILES_Y = c_tiles_y
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic               i_out_ready,
  output logic               o_out_valid,
  output logic               o_lb_write,
  output logic               o_lb_read,
  output logic [c_idx_w-1:0] o_tile_x,
  output logic [c_idx_w-1:0] o_tile_y,
  output logic               o_first_tile,
  output logic               o_last_tile,
  output logic               o_frame_done,
  output logic               o_busy
);

  localparam int               CNT_W      = cnt_width(TILE_N);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TILE_N - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [CNT_W-1:0] r_rd_cnt;
  logic             r_frame_done;

  logic w_in_fill;
  logic w_in_drain;
  logic w_start;
  logic w_wr_last;
  logic w_rd_last;
  logic w_first;
  logic w_last;

  assign w_in_fill  = (r_state == c_st_fill);
  assign w_in_drain = (r_state == c_st_drain);
  assign w_start    = (r_state == c_st_idle) && i_enable;

  // Strobes are masked by reset so the line buffer never sees a stray beat
  // while both blocks are being reset together.
  assign o_in_ready  = w_in_fill & ~i_rst;
  assign o_lb_write  = o_in_ready & i_in_valid;
  assign o_out_valid = w_in_drain & i_out_ready & ~i_rst;
  assign o_lb_read   = o_out_valid;

  assign w_wr_last = o_lb_write && (r_wr_cnt == c_cnt_last);
  assign w_rd_last = o_lb_read && (r_rd_cnt == c_cnt_last);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= c_st_idle;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (i_enable) r_state <= c_st_fill;
        end
        c_st_fill: begin
          if (o_lb_write) begin
            if (w_wr_last) begin
              r_wr_cnt <= '0;
              r_state  <= c_st_drain;
            end else begin
              r_wr_cnt <= r_wr_cnt + c_cnt_one;
            end
          end
        end
        c_st_drain: begin
          if (o_lb_read) begin
            if (w_rd_last) begin
              r_rd_cnt <= '0;
              if (w_last) begin
                r_state      <= c_st_idle;
                r_frame_done <= 1'b1;
              end else begin
                r_state <= c_st_fill;
              end
            end else begin
              r_rd_cnt <= r_rd_cnt + c_cnt_one;
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  lb_tile_pos_cnt #(
    .TILES_X (TILES_X),
    .TILES_Y (TILES_Y),
    .IDX_W   (c_idx_w)
  ) u_pos_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_start),
    .i_advance (w_rd_last),
    .o_x       (o_tile_x),
    .o_y       (o_tile_y),
    .o_first   (w_first),
    .o_last    (w_last)
  );

  assign o_first_tile = w_first & w_in_drain;
  assign o_last_tile  = w_last & w_in_drain;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_lb_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lb_tile_ctrl
// Brief    : Randomised bench for lb_tile_ctrl with a transaction-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_lb_tile_ctrl;

  localparam int N  = 8;
  localparam int TX = 3;
  localparam int TY = 2;
  localparam int NT = TX * TY;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       vld = 1'b0;
  logic       rdy = 1'b0;
  logic       in_ready, out_valid, lb_write, lb_read;
  logic [7:0] tile_x, tile_y;
  logic       first_tile, last_tile, frame_done, busy;

  always #5 clk = ~clk;

  lb_tile_ctrl #(
    .TILE_N  (N),
    .TILES_X (TX),
    .TILES_Y (TY)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_in_valid   (vld),
    .o_in_ready   (in_ready),
    .i_out_ready  (rdy),
    .o_out_valid  (out_valid),
    .o_lb_write   (lb_write),
    .o_lb_read    (lb_read),
    .o_tile_x     (tile_x),
    .o_tile_y     (tile_y),
    .o_first_tile (first_tile),
    .o_last_tile  (last_tile),
    .o_frame_done (frame_done),
    .o_busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tile progress as plain counts and a linear tile number.
  bit          m_known  = 1'b0;
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int          m_wr = 0, m_rd = 0, m_tile = 0;
  logic [63:0] m_rows [N];

  // Line buffer stand-in driven only by the DUT strobes.
  logic [63:0] lb_mem [N];
  int          lb_wp = 0, lb_rp = 0;

  logic [63:0] din;
  bit          prev_rst = 1'b0;
  int          done_seen = 0;

  function automatic logic [63:0] lb_col(input int c);
    logic [63:0] col;
    for (int r = 0; r < N; r++) col[r*8 +: 8] = lb_mem[r][c*8 +: 8];
    return col;
  endfunction

  function automatic logic [63:0] ref_col(input int c);
    logic [63:0] col;
    for (int r = 0; r < N; r++) col[r*8 +: 8] = m_rows[r][c*8 +: 8];
    return col;
  endfunction

  task automatic step(input bit t_rst, input bit t_en, input bit t_vld, input bit t_rdy);
    bit e_ready, e_write, e_read, e_drain, cap_w, cap_r;
    rst = t_rst;
    en  = t_en;
    vld = t_vld;
    rdy = t_rdy;
    din = {$urandom, $urandom};
    #1;
    e_drain = m_active && (m_wr == N);
    e_ready = !t_rst && m_active && (m_wr < N);
    e_write = e_ready && t_vld;
    e_read  = !t_rst && e_drain && t_rdy;
    if (frame_done) done_seen++;
    if (m_known && !(t_rst && !prev_rst)) begin
      check_val("in_ready",   in_ready,   e_ready);
      check_val("lb_write",   lb_write,   e_write);
      check_val("lb_read",    lb_read,    e_read);
      check_val("out_valid",  out_valid,  e_read);
      check_val("busy",       busy,       m_active);
      check_val("frame_done", frame_done, m_done);
      check_val("tile_x",     tile_x,     m_tile % TX);
      check_val("tile_y",     tile_y,     m_tile / TX);
      check_val("first_tile", first_tile, e_drain && (m_tile == 0));
      check_val("last_tile",  last_tile,  e_drain && (m_tile == NT - 1));
      if (e_read && lb_read) check_val("column", lb_col(lb_rp), ref_col(m_rd));
    end
    cap_w = lb_write;
    cap_r = lb_read;
    @(posedge clk);
    if (t_rst) begin
      lb_wp = 0;
      lb_rp = 0;
    end else begin
      if (cap_w) begin
        lb_mem[lb_wp] = din;
        lb_wp = (lb_wp + 1) % N;
      end
      if (cap_r) lb_rp = (lb_rp + 1) % N;
    end
    if (t_rst) begin
      m_known  = 1'b1;
      m_active = 1'b0;
      m_done   = 1'b0;
      m_wr     = 0;
      m_rd     = 0;
      m_tile   = 0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (t_en) begin
          m_active = 1'b1;
          m_tile   = 0;
        end
      end else if (e_write) begin
        m_rows[m_wr] = din;
        m_wr++;
      end else if (e_read) begin
        m_rd++;
        if (m_rd == N) begin
          m_rd = 0;
          m_wr = 0;
          if (m_tile == NT - 1) begin
            m_active = 1'b0;
            m_tile   = 0;
            m_done   = 1'b1;
          end else begin
            m_tile++;
          end
        end
      end
    end
    prev_rst = t_rst;
    #1;
  endtask

  initial begin
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Continuous flow over a whole reduced frame.
    done_seen = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (NT * 2 * N + 4) step(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("done_count", done_seen, 1);
    check_val("idle_after_frame", busy, 1'b0);

    // Alternating input valid, then periodic output stalls of 3 cycles.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, (i % 2) == 0, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1, !((i % 16) >= 11 && (i % 16) < 14));
    repeat (200) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Reset after five accepted rows, then a clean tile.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2 * N + 4) step(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (200) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Enable held high through the frame boundary.
    done_seen = 0;
    repeat (2 * NT * 2 * N + 8) step(1'b0, 1'b1, 1'b1, 1'b1);
    check_val("done_count_en_high", done_seen >= 1, 1'b1);

    // Random traffic with rare resets.
    repeat (3000)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
